// File: rtl/run_length_logger.sv
// Run-length logger: measures every run of detector activity, queues each
// run length in a small show-ahead FIFO and keeps run/drop statistics.
//
// state | meaning
// IDLE  | no run in progress, waiting for det_in
// RUN   | run in progress, len_cnt counting input bits
// PUSH  | run ended last edge; commit len_cnt this cycle
module run_length_logger #(
  parameter int LEN_W = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             det_in,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LEN_W-1:0] out_len,
  output logic [CNT_W-1:0] run_count,
  output logic             drop_flag,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [LEN_W-1:0] LEN_MAX   = '1;
  localparam logic [LEN_W-1:0] LEN_START = LEN_W'(3);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PUSH = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_cnt, len_nxt;

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [LEN_W-1:0] mem [DEPTH];
  logic             empty, full, push_req, pop, wr_en;

  // FSM state and run-length register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      len_cnt <= '0;
    end else begin
      state   <= state_nxt;
      len_cnt <= len_nxt;
    end
  end

  // Next-state and length update; det_in is first seen on the 3rd one of a run
  always_comb begin
    state_nxt = state;
    len_nxt   = len_cnt;
    case (state)
      IDLE: begin
        if (det_in) begin
          state_nxt = RUN;
          len_nxt   = LEN_START;
        end
      end
      RUN: begin
        if (det_in) begin
          if (len_cnt != LEN_MAX) len_nxt = len_cnt + LEN_W'(1);
        end else begin
          state_nxt = PUSH;
        end
      end
      PUSH: begin
        if (det_in) begin
          state_nxt = RUN;
          len_nxt   = LEN_START;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        len_nxt   = '0;
      end
    endcase
  end

  // FIFO status and handshake; a full FIFO still accepts a push if the head
  // leaves in the same cycle (the freed slot is the one being written)
  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    out_valid = !empty;
    push_req  = (state == PUSH);
    pop       = out_valid && out_ready;
    wr_en     = push_req && (!full || pop);
    out_len   = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
    busy      = (state != IDLE);
  end

  // FIFO pointers; clr flushes and wins over push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // FIFO storage; contents are qualified by the pointers so need no reset
  always_ff @(posedge clk) begin
    if (!clr && wr_en) mem[wr_ptr[AW-1:0]] <= len_cnt;
  end

  // Run statistics: every completed run counts, even when its record is dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_count <= '0;
      drop_flag <= 1'b0;
    end else if (clr) begin
      run_count <= '0;
      drop_flag <= 1'b0;
    end else if (push_req) begin
      if (run_count != CNT_MAX) run_count <= run_count + CNT_W'(1);
      if (full && !pop) drop_flag <= 1'b1;
    end
  end

endmodule
